bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_pkg.sv | 18 +
 rtl/bin2bcd_seq_bcd_digit_adj.sv | 20 ++
 rtl/bin2bcd_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_e      : converter FSM states
//   BcdWidth     : bits per BCD digit
//   AddThreshold : digit value at or above which the add-3 correction applies
//   AddValue     : correction added to a digit before each shift
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam int unsigned BcdWidth     = 4;
    localparam int unsigned AddThreshold = 5;
    localparam int unsigned AddValue     = 3;

endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// Combinational double-dabble correction for one BCD digit: a digit of 5 or more
// gets 3 added so that the following left shift carries correctly into the next digit.
//   digit_i : working digit before correction
//   digit_o : corrected digit, ready to be shifted
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BcdWidth-1:0] digit_i,
    output logic [BcdWidth-1:0] digit_o
);

    always_comb begin
        if (digit_i >= BcdWidth'(AddThreshold)) begin
            digit_o = digit_i + BcdWidth'(AddValue);
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one operand bit per clock, MSB first.
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous active-high reset
//   start    : request a conversion of bin_in (ignored while busy)
//   bin_in   : unsigned operand, sampled on an accepted start
//   busy     : high while a conversion is in SHIFT or DONE
//   done     : one-cycle pulse when bcd_out/lz_mask/overflow are updated
//   bcd_out  : packed BCD result, digit 0 in bits [3:0]
//   lz_mask  : bit i set when digit i is a leading zero (bit 0 always clear)
//   overflow : result did not fit in DIGITS digits
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_WIDTH = 16,
    parameter int unsigned DIGITS    = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [BIN_WIDTH-1:0]         bin_in,
    output logic                         busy,
    output logic                         done,
    output logic [BcdWidth*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]            lz_mask,
    output logic                         overflow
);

    localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);
    localparam int unsigned BcdW = BcdWidth * DIGITS;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [BcdW-1:0]      dig_q, dig_d;
    logic                 ovf_q, ovf_d;
    logic [BcdW-1:0]      bcd_q, bcd_d;
    logic [DIGITS-1:0]    lz_q, lz_d;
    logic                 ov_out_q, ov_out_d;
    logic                 done_q, done_d;

    logic [BcdW-1:0]      adj;
    logic [DIGITS-1:0]    lz_calc;
    logic                 all_zero;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (dig_q[g*BcdWidth +: BcdWidth]),
            .digit_o (adj[g*BcdWidth +: BcdWidth])
        );
    end

    // Leading-zero mask from the final digits, scanned from the top digit down.
    always_comb begin
        lz_calc  = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero & (dig_q[i*BcdWidth +: BcdWidth] == '0);
            lz_calc[i] = all_zero;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        dig_d    = dig_q;
        ovf_d    = ovf_q;
        bcd_d    = bcd_q;
        lz_d     = lz_q;
        ov_out_d = ov_out_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StShift;
                    bin_d   = bin_in;
                    dig_d   = '0;
                    cnt_d   = CntW'(BIN_WIDTH);
                    ovf_d   = 1'b0;
                end
            end
            StShift: begin
                // {digits, operand} shifted left as one register after correction.
                dig_d = {adj[BcdW-2:0], bin_q[BIN_WIDTH-1]};
                bin_d = bin_q << 1;
                ovf_d = ovf_q | adj[BcdW-1];
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bcd_d    = dig_q;
                lz_d     = lz_calc;
                ov_out_d = ovf_q;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bin_q    <= '0;
            dig_q    <= '0;
            ovf_q    <= 1'b0;
            bcd_q    <= '0;
            lz_q     <= {{(DIGITS-1){1'b1}}, 1'b0};
            ov_out_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            dig_q    <= dig_d;
            ovf_q    <= ovf_d;
            bcd_q    <= bcd_d;
            lz_q     <= lz_d;
            ov_out_q <= ov_out_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign lz_mask  = lz_q;
    assign overflow = ov_out_q;

endmodule
